// File: rtl/logic_sel_sweeper.sv
// logic_sel_sweeper: sweeps all 8 {sel,a,b} vectors through the AND/NAND cell and records mismatches (optional LOGIC_SWEEP_FIRST_FAIL_EN adds first-fail capture)
module logic_sel_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a_o,
  output logic       b_o,
  output logic       sel_o,
  input  logic       out_and_i,
  input  logic       out_nand_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
`ifdef LOGIC_SWEEP_FIRST_FAIL_EN
  ,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_idx
`endif
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [3:0] SETTLE  = 4'(SETTLE_CYCLES);
  logic [2:0] r_state;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_sel;
  logic [3:0] r_err;
  logic [7:0] r_fv;
  logic       w_exp_and;
  logic       w_exp_nand;
  logic       w_mis;
`ifdef LOGIC_SWEEP_FIRST_FAIL_EN
  logic       r_ff_valid;
  logic [2:0] r_ff_idx;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_idx   = r_ff_idx;
`endif
  assign w_exp_and  = ~r_idx[2] & r_idx[1] & r_idx[0];
  assign w_exp_nand = r_idx[2] & ~(r_idx[1] & r_idx[0]);
  assign w_mis      = (out_and_i != w_exp_and) | (out_nand_i != w_exp_nand);
  assign a_o        = r_a;
  assign b_o        = r_b;
  assign sel_o      = r_sel;
  assign busy       = (r_state == S_DRIVE) | (r_state == S_WAIT) | (r_state == S_CHECK);
  assign done       = r_state == S_DONE;
  assign pass       = done & (r_err == 4'd0);
  assign err_count  = r_err;
  assign fail_vec   = r_fv;
  // Sweep sequencer: drive a vector, let the cell settle, then grade its response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= 4'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_sel   <= 1'b0;
      r_err   <= 4'd0;
      r_fv    <= 8'd0;
`ifdef LOGIC_SWEEP_FIRST_FAIL_EN
      r_ff_valid <= 1'b0;
      r_ff_idx   <= 3'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_err   <= 4'd0;
            r_fv    <= 8'd0;
            r_idx   <= 3'd0;
            r_state <= S_DRIVE;
`ifdef LOGIC_SWEEP_FIRST_FAIL_EN
            r_ff_valid <= 1'b0;
            r_ff_idx   <= 3'd0;
`endif
          end
        end
        S_DRIVE: begin
          {r_sel, r_a, r_b} <= r_idx;
          r_cnt             <= SETTLE;
          r_state           <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt   <= r_cnt - 4'd1;
          r_state <= (r_cnt == 4'd1) ? S_CHECK : S_WAIT;
        end
        S_CHECK: begin
          if (w_mis) begin
            r_fv[r_idx] <= 1'b1;
            r_err       <= r_err + 4'd1;
`ifdef LOGIC_SWEEP_FIRST_FAIL_EN
            if (!r_ff_valid) begin
              r_ff_valid <= 1'b1;
              r_ff_idx   <= r_idx;
            end
`endif
          end
          r_idx   <= (r_idx == 3'd7) ? r_idx : r_idx + 3'd1;
          r_state <= (r_idx == 3'd7) ? S_DONE : S_DRIVE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_logic_sel_sweeper.sv
// tb_logic_sel_sweeper: randomized fault-injection bench with a done-triggered scoreboard
module tb_logic_sel_sweeper;
  localparam int S = 2;
  typedef struct {
    logic [7:0] fv;
    logic [3:0] ec;
    logic       ffv;
    logic [2:0] ffi;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       a_o, b_o, sel_o;
  logic       out_and, out_nand;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_vec;
  logic       ffv;
  logic [2:0] ffi;
  int         mode = 0;
  logic [7:0] am = 8'd0;
  logic [7:0] nm = 8'd0;
  int         errors = 0;
  int         checks = 0;
  exp_t       q[$];
  logic_sel_sweeper #(.SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a_o(a_o),
    .b_o(b_o),
    .sel_o(sel_o),
    .out_and_i(out_and),
    .out_nand_i(out_nand),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .fail_vec(fail_vec)
`ifdef LOGIC_SWEEP_FIRST_FAIL_EN
    ,
    .first_fail_valid(ffv),
    .first_fail_idx(ffi)
`endif
  );
`ifndef LOGIC_SWEEP_FIRST_FAIL_EN
  assign ffv = 1'b0;
  assign ffi = 3'd0;
`endif
  always #5 clk = ~clk;
  // Cell under test: ideal truth table, optionally corrupted per mode
  always_comb begin
    logic ia, in_;
    logic [2:0] v;
    v   = {sel_o, a_o, b_o};
    ia  = !sel_o && a_o && b_o;
    in_ = sel_o && !(a_o && b_o);
    out_and  = (mode == 1) ? 1'b0 : ia ^ (mode == 3 && am[v]);
    out_nand = (mode == 2) ? 1'b1 : in_ ^ (mode == 3 && nm[v]);
  end
  function automatic exp_t expect_for(int m, logic [7:0] fa, logic [7:0] fn);
    exp_t e;
    e = '{fv: 8'd0, ec: 4'd0, ffv: 1'b0, ffi: 3'd0};
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      logic bad;
      vv  = 3'(v);
      bad = (m == 1) ? (!vv[2] && vv[1] && vv[0]) :
            (m == 2) ? !(vv[2] && !(vv[1] && vv[0])) :
            (m == 3) ? (fa[v] || fn[v]) : 1'b0;
      if (bad) begin
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffi = vv;
        end
        e.fv[v] = 1'b1;
        e.ec    = e.ec + 4'd1;
      end
    end
    return e;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic wait_done();
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask
  task automatic sweep(int m, logic [7:0] fa, logic [7:0] fn, bit hold);
    mode = m;
    am   = fa;
    nm   = fn;
    q.push_back(expect_for(m, fa, fn));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done();
  endtask
  // Monitor: on each rising done, pop and grade the oldest expectation
  initial begin
    int   cnt = 0;
    logic pd  = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
        pd  = 1'b0;
      end else begin
        if (busy) cnt++;
        if (done && !pd) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = q.pop_front();
            chk("fail_vec", 32'(fail_vec), 32'(e.fv));
            chk("err_count", 32'(err_count), 32'(e.ec));
            chk("pass", 32'(pass), 32'(e.ec == 4'd0));
            chk("busy_cycles", 32'(cnt), 32'(8 * (S + 2)));
`ifdef LOGIC_SWEEP_FIRST_FAIL_EN
            chk("first_fail_valid", 32'(ffv), 32'(e.ffv));
            if (e.ffv) chk("first_fail_idx", 32'(ffi), 32'(e.ffi));
`endif
          end
          cnt = 0;
        end
        pd = done;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", 32'({a_o, b_o, sel_o, busy, done, pass}), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_fv", 32'(fail_vec), 32'd0);
    chk("rst_ffv", 32'(ffv), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start", 32'({busy, done}), 32'd0);
    sweep(0, 8'd0, 8'd0, 1'b0);
    sweep(1, 8'd0, 8'd0, 1'b0);
    sweep(2, 8'd0, 8'd0, 1'b0);
    // reset during WAIT of vector 4
    mode = 2;
    q.push_back(expect_for(2, 8'd0, 8'd0));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("pre_rst_sel", 32'({sel_o, a_o, b_o}), 32'd4);
    chk("pre_rst_err", 32'(err_count), 32'd4);
    reset = 1'b1;
    #1;
    chk("mid_rst_outs", 32'({a_o, b_o, sel_o, busy, done, pass}), 32'd0);
    chk("mid_rst_res", 32'({err_count, fail_vec}), 32'd0);
    void'(q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", 32'(done), 32'd0);
    sweep(0, 8'd0, 8'd0, 1'b0);
    // start held high across a whole sweep, then restart from DONE
    sweep(2, 8'd0, 8'd0, 1'b1);
    q.push_back(expect_for(2, 8'd0, 8'd0));
    @(negedge clk);
    chk("restart_done_drop", 32'(done), 32'd0);
    chk("restart_err_clear", 32'(err_count), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sweep(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom & ($urandom_range(0, 1) ? 32'hff : 32'h0)), 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logic_sel_sweeper.md
Name: logic_sel_sweeper

Overview:
- Stimulus/check engine for the selectable AND/NAND logic cell. It drives that cell's inputs A, B and Sel, and samples its Out_AND and Out_NAND outputs.
- Each sweep covers all 8 input combinations in order. It checks every response against the cell's truth table and reports a per-vector fail map plus an error count.
- Used as the self-test front end for the logic-cell exercises, on the clocked side of the design.

Parameters:
- SETTLE_CYCLES, 2, cycles to hold a vector before sampling the cell outputs; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin sweep; sampled only in IDLE or DONE.
- a_o  output  1  drives cell input A.
- b_o  output  1  drives cell input B.
- sel_o  output  1  drives cell input Sel.
- out_and_i  input  1  cell Out_AND.
- out_nand_i  input  1  cell Out_NAND.
- busy  output  1  high while a sweep runs (DRIVE/WAIT/CHECK).
- done  output  1  high in DONE; held until the next start or reset.
- pass  output  1  done && (err_count == 0).
- err_count  output  4  mismatching vectors in the last sweep, 0..8.
- fail_vec  output  8  bit i set if vector i mismatched.

Behaviour:
- Reset (async, immediate, any state): state=IDLE; a_o, b_o, sel_o, busy, done, pass = 0; err_count = 0; fail_vec = 0; idx = 0; wait counter = 0.
- Vector index idx[2:0] = {sel, a, b}, swept 0 to 7 ascending.
- Expected response:
  - sel=0: and = a&b, nand = 0.
  - sel=1: and = 0, nand = ~(a&b).
- A mismatch on either line fails the vector.
- States:
  - IDLE: start=1 clears err_count, fail_vec and idx; go to DRIVE.
  - DRIVE: register a_o, b_o, sel_o from idx; load wait counter with SETTLE_CYCLES; go to WAIT.
  - WAIT: decrement each cycle; when counter reaches 1, go to CHECK. Exactly SETTLE_CYCLES cycles are spent in WAIT.
  - CHECK: compare out_and_i/out_nand_i against the expected response for the registered idx.
    - On mismatch: set fail_vec[idx] and increment err_count.
    - If idx==7, go to DONE; otherwise idx+1 and go to DRIVE.
  - DONE: done=1; a_o/b_o/sel_o hold the last vector. start=1 behaves as in IDLE (clear, restart) and done drops on the next cycle.
- Timing:
  - Each vector takes SETTLE_CYCLES+2 edges.
  - done is first high after edge 8*(SETTLE_CYCLES+2), counting the start-sampling edge as 0 (edge 32 at default).
- start while busy is ignored; no restart mid-sweep.
- Cell inputs are sampled only in CHECK; glitches during WAIT are irrelevant.
- Reset mid-sweep aborts the sweep and clears all results; a fresh start is required.
- err_count never exceeds 8, so no saturation logic is needed.

Optional Feature:
- Macro: LOGIC_SWEEP_FIRST_FAIL_EN.
- Defined: adds outputs first_fail_valid (1 bit) and first_fail_idx (3 bits).
  - Both clear on reset and on start.
  - On the first mismatch of a sweep, capture idx and set valid; later mismatches leave them unchanged.
- Undefined: those ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset asserted at t=0, no start -> all outputs 0; state IDLE; busy=0.
- Correct cell model attached, start pulse (SETTLE=2) -> busy goes high; done high after edge 32; pass=1; err_count=0; fail_vec=8'h00.
- Out_AND stuck-at-0 fault -> only vector 3 (sel=0,a=1,b=1) fails: fail_vec=8'h08, err_count=1, pass=0. Optional build: first_fail_idx=3.
- Out_NAND stuck-at-1 fault -> vectors 0,1,2,3,7 fail: fail_vec=8'h8F, err_count=5. Optional build: first_fail_idx=0.
- Reset pulse during WAIT of vector 4 -> outputs cleared immediately, no done. A new start runs a full 32-edge sweep with fresh counts.
- start held high throughout a sweep -> no restart while busy. In DONE, start restarts: done drops next cycle and err_count clears.
